// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU memory stage vs. debug/loader port.
// CPU has priority; aging guarantees debug progress; a bounded lock allows atomic debug bursts.
module dmem_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned LOCK_MAX = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [2:0]       cpu_addrmode,
   input  logic [WIDTH-1:0] cpu_addr,
   input  logic [WIDTH-1:0] cpu_wdata,
   output logic [WIDTH-1:0] cpu_rdata,
   output logic             cpu_stall,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic             dbg_lock,
   input  logic [2:0]       dbg_addrmode,
   input  logic [WIDTH-1:0] dbg_addr,
   input  logic [WIDTH-1:0] dbg_wdata,
   output logic             dbg_gnt,
   output logic             dbg_rvalid,
   output logic [WIDTH-1:0] dbg_rdata,
   output logic             mem_we,
   output logic [2:0]       mem_addrmode,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);
   localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam int unsigned LOCK_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

   typedef enum logic {ARB, LOCK} state_t;

   state_t            state;
   logic [WAIT_W-1:0] waitCnt;
   logic [LOCK_W-1:0] lockCnt;
   logic              cpuBypass;
   logic              cpuGnt;
   logic              dbgGnt;
   logic              agedWin;
   logic              lockFull;

   assign agedWin  = (waitCnt == WAIT_W'(MAX_WAIT)) && !cpuBypass;
   assign lockFull = (lockCnt == LOCK_W'(LOCK_MAX));

   // Same-cycle grant; nothing is granted while reset is held so mem_we drops at once
   always_comb begin
      cpuGnt = 1'b0;
      dbgGnt = 1'b0;
      if (!rst) begin
         if (state == LOCK) begin
            dbgGnt = dbg_req;
         end else begin
            dbgGnt = dbg_req && (!cpu_req || agedWin);
            cpuGnt = cpu_req && !dbgGnt;
         end
      end
   end

   // Memory port mux; idle port drives zeros
   always_comb begin
      mem_we       = 1'b0;
      mem_addrmode = 3'b000;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (cpuGnt) begin
         mem_we       = cpu_we;
         mem_addrmode = cpu_addrmode;
         mem_addr     = cpu_addr;
         mem_wdata    = cpu_wdata;
      end else if (dbgGnt) begin
         mem_we       = dbg_we;
         mem_addrmode = dbg_addrmode;
         mem_addr     = dbg_addr;
         mem_wdata    = dbg_wdata;
      end
   end

   assign cpu_rdata = mem_rdata;
   assign cpu_stall = cpu_req && !cpuGnt;
   assign dbg_gnt   = dbgGnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB;
         waitCnt    <= '0;
         lockCnt    <= '0;
         cpuBypass  <= 1'b0;
         dbg_rvalid <= 1'b0;
         dbg_rdata  <= '0;
      end else begin
         dbg_rvalid <= dbgGnt && !dbg_we;
         if (dbgGnt && !dbg_we) dbg_rdata <= mem_rdata;

         if (dbg_req && !dbgGnt) begin
            if (waitCnt != WAIT_W'(MAX_WAIT)) waitCnt <= waitCnt + WAIT_W'(1);
         end else begin
            waitCnt <= '0;
         end

         case (state)
            ARB: begin
               // Bypass only matters while the CPU is actually contending
               cpuBypass <= 1'b0;
               if (dbgGnt && dbg_lock && !(cpuBypass && cpu_req)) begin
                  state   <= LOCK;
                  lockCnt <= LOCK_W'(1);
               end
            end
            LOCK: begin
               if (!dbg_lock || !dbg_req || lockFull) begin
                  state     <= ARB;
                  lockCnt   <= '0;
                  cpuBypass <= lockFull;
               end else begin
                  lockCnt <= lockCnt + LOCK_W'(1);
               end
            end
            default: state <= ARB;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: word memory model, shadow of expected contents,
// and a queue of expected debug read responses.
module tb_dmem_arbiter;
   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             cpu_req, cpu_we;
   logic [2:0]       cpu_addrmode;
   logic [WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic             cpu_stall;
   logic             dbg_req, dbg_we, dbg_lock;
   logic [2:0]       dbg_addrmode;
   logic [WIDTH-1:0] dbg_addr, dbg_wdata;
   logic             dbg_gnt, dbg_rvalid;
   logic [WIDTH-1:0] dbg_rdata;
   logic             mem_we;
   logic [2:0]       mem_addrmode;
   logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

   dmem_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(4), .LOCK_MAX(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addrmode(cpu_addrmode),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addrmode(dbg_addrmode),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_we(mem_we), .mem_addrmode(mem_addrmode), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Word-addressed memory: combinational read, synchronous write
   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

   logic [31:0] shadow [0:255];
   logic [31:0] rdQ [$];
   bit          rdPending;
   int          checks;
   int          failures;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // One clock cycle: called at posedge+1, drives, checks at negedge, returns at next posedge+1
   task automatic step(input string tag, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input logic dr, input logic dw, input logic dl,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic expStall, input logic expDg);
      logic        expCg, expWe;
      logic [31:0] expAddr, expWd;
      chk({tag, ":rvalid"}, 32'(dbg_rvalid), 32'(rdPending));
      if (rdPending) begin
         chk({tag, ":rdata"}, dbg_rdata, rdQ.pop_front());
         rdPending = 1'b0;
      end
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd; cpu_addrmode = 3'b010;
      dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dwd;
      dbg_addrmode = 3'b010;
      @(negedge clk);
      expCg   = cr & ~expStall;
      expWe   = (expCg & cw) | (expDg & dw);
      expAddr = expCg ? ca : (expDg ? da : 32'h0);
      expWd   = expCg ? cwd : (expDg ? dwd : 32'h0);
      chk({tag, ":stall"}, 32'(cpu_stall), 32'(expStall));
      chk({tag, ":dgnt"}, 32'(dbg_gnt), 32'(expDg));
      chk({tag, ":mwe"}, 32'(mem_we), 32'(expWe));
      chk({tag, ":maddr"}, mem_addr, expAddr);
      chk({tag, ":mwdata"}, mem_wdata, expWd);
      if (expCg && !cw) chk({tag, ":crdata"}, cpu_rdata, shadow[ca[9:2]]);
      if (expDg && !dw) begin
         rdQ.push_back(shadow[da[9:2]]);
         rdPending = 1'b1;
      end
      if (expCg && cw) shadow[ca[9:2]] = cwd;
      if (expDg && dw) shadow[da[9:2]] = dwd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      checks = 0; failures = 0; rdPending = 1'b0;
      for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
      mem[8] = 32'h12345678; shadow[8] = 32'h12345678;
      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addrmode = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addrmode = 0; dbg_addr = 32'h20; dbg_wdata = 32'hFFFF;

      // Reset state, with a debug write pending that must not be granted
      #12;
      chk("rst:rvalid", 32'(dbg_rvalid), 32'h0);
      chk("rst:rdata", dbg_rdata, 32'h0);
      chk("rst:mwe", 32'(mem_we), 32'h0);
      chk("rst:dgnt", 32'(dbg_gnt), 32'h0);
      @(negedge clk);
      dbg_req = 0; dbg_we = 0; dbg_lock = 0;
      rst = 1'b0;
      @(posedge clk); #1;

      // CPU-only store then load
      step("cpu_st", 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
      step("cpu_ld", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);

      // Debug read latency
      step("dbg_rd", 0, 0, 0, 0, 1, 0, 0, 32'h20, 0, 0, 1);
      idle();
      idle();

      // Contention aging: debug wins on cycle 4 only
      for (int i = 0; i < 6; i++)
         step($sformatf("age%0d", i), 1, 0, 32'h10, 0, 1, 0, 0, 32'h20, 0, i == 4, i == 4);
      idle();

      // Dropping dbg_req clears the aging count
      for (int i = 0; i < 9; i++)
         step($sformatf("wclr%0d", i), 1, 0, 32'h10, 0, i != 3, 0, 0, 32'h20, 0, i == 8, i == 8);
      idle();

      // Lock burst of three writes, lock dropped on the third
      for (int i = 0; i < 4; i++)
         step($sformatf("lkw%0d", i), 1, 0, 32'h10, 0, 1, 1, 1, 32'h40, 32'hA0A0A0A0, 0, 0);
      step("burst0", 1, 0, 32'h10, 0, 1, 1, 1, 32'h40, 32'hA0A0A0A0, 1, 1);
      step("burst1", 1, 0, 32'h10, 0, 1, 1, 1, 32'h44, 32'hB1B1B1B1, 1, 1);
      step("burst2", 1, 0, 32'h10, 0, 1, 1, 0, 32'h48, 32'hC2C2C2C2, 1, 1);
      step("burst_cpu", 1, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0, 0);
      step("burst_chk", 1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0);

      // Forced release after 16 locked cycles, then bypass and re-aging before relock
      for (int i = 0; i < 27; i++)
         step($sformatf("force%0d", i), 1, 0, 32'h10, 0, 1, 0, 1, 32'h40, 0,
              (i >= 4 && i <= 20) || i >= 25, (i >= 4 && i <= 20) || i >= 25);
      step("force_exit", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();

      // Reset mid-lock
      step("rl0", 0, 0, 0, 0, 1, 0, 1, 32'h20, 0, 0, 1);
      step("rl1", 0, 0, 0, 0, 1, 0, 1, 32'h20, 0, 0, 1);
      chk("rl:rvalid", 32'(dbg_rvalid), 32'h1);
      chk("rl:rdata", dbg_rdata, rdQ.pop_front());
      rdPending = 1'b0;
      dbg_we = 1; dbg_wdata = 32'h0BAD0BAD;
      #2;
      rst = 1'b1;
      #1;
      chk("rl_rst:mwe", 32'(mem_we), 32'h0);
      chk("rl_rst:dgnt", 32'(dbg_gnt), 32'h0);
      chk("rl_rst:rvalid", 32'(dbg_rvalid), 32'h0);
      chk("rl_rst:rdata", dbg_rdata, 32'h0);
      @(negedge clk);
      dbg_req = 0; dbg_we = 0; dbg_lock = 0;
      rst = 1'b0;
      @(posedge clk); #1;
      step("rl_arb", 1, 0, 32'h20, 0, 1, 0, 1, 32'h40, 0, 0, 0);
      idle();
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU memory stage (requester 0) and a debug/loader port (requester 1), e.g. for testbench program/data load or live memory inspection.
- Memory access is combinational read with synchronous write. At most one requester is granted per cycle.
- The CPU has priority. An aging counter guarantees debug progress. A bounded lock lets debug perform atomic bursts.
- The CPU stall output holds the pipeline (F/D/E/M) while the CPU is denied.

Parameters:
- WIDTH, 32, data/address width.
- MAX_WAIT, 4, number of consecutive denied debug-request cycles after which debug wins one contested cycle.
- LOCK_MAX, 16, maximum cycles debug may hold the lock before forced release.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU memory-stage access (load or store) this cycle.
- cpu_we  in  1  CPU store.
- cpu_addrmode  in  3  CPU funct3 (byte/half/word, signedness).
- cpu_addr  in  WIDTH  CPU byte address.
- cpu_wdata  in  WIDTH  CPU store data.
- cpu_rdata  out  WIDTH  load data, combinational pass-through of mem_rdata.
- cpu_stall  out  1  cpu_req & ~cpu_gnt.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug write.
- dbg_lock  in  1  request or extend exclusive ownership.
- dbg_addrmode  in  3  debug funct3.
- dbg_addr  in  WIDTH  debug byte address.
- dbg_wdata  in  WIDTH  debug write data.
- dbg_gnt  out  1  debug access performed this cycle.
- dbg_rvalid  out  1  registered read-response pulse.
- dbg_rdata  out  WIDTH  registered read data.
- mem_we  out  1  to data memory write_enable.
- mem_addrmode  out  3  to data memory addrmode.
- mem_addr  out  WIDTH  to data memory (the memory wrapper splits the byte-select bits).
- mem_wdata  out  WIDTH  to data memory.
- mem_rdata  in  WIDTH  from data memory.

Behaviour:
- Reset: state=ARB, wait_cnt=0, lock_cnt=0, cpu_bypass=0, dbg_rvalid=0, dbg_rdata=0. Reset takes effect immediately, including mid-lock.
- Grants (combinational, same cycle as request). In ARB:
  - Only one requester active: that requester is granted.
  - Both active: CPU is granted unless wait_cnt==MAX_WAIT and cpu_bypass==0; in that case debug is granted.
  - In LOCK: dbg_gnt=dbg_req; cpu_gnt=0.
- Memory mux: granted port's we/addrmode/addr/wdata drive the mem_* outputs. With no grant: mem_we=0, all other mem_* = 0.
  - mem_we is never asserted for a non-granted requester.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle dbg_req=1 & dbg_gnt=0. Clears when dbg_gnt=1 or dbg_req=0.
- FSM ARB -> LOCK: dbg_gnt & dbg_lock. lock_cnt is loaded with 1.
- FSM LOCK -> ARB, on any of:
  - dbg_lock=0 (that cycle's access is still granted if dbg_req=1);
  - dbg_req=0;
  - lock_cnt==LOCK_MAX (forced). On a forced exit, cpu_bypass is set to 1 for the next ARB cycle.
- In LOCK: lock_cnt increments each cycle.
- cpu_bypass: while set, debug cannot win via aging and cannot re-enter LOCK. It clears after one ARB cycle in which cpu_req=1, or immediately if cpu_req=0.
- Debug read response: at the posedge ending a cycle with dbg_gnt & ~dbg_we:
  - dbg_rdata <= mem_rdata and dbg_rvalid <= 1.
  - Otherwise dbg_rvalid <= 0 and dbg_rdata holds its value.
  - Latency is 1 cycle. Back-to-back reads give one rvalid per cycle.
- CPU: cpu_rdata=mem_rdata unconditionally. It is valid only when cpu_gnt=1.
  - The pipeline must hold the M stage while cpu_stall=1; a stalled store is re-presented by the CPU and performed once.
- Addresses and modes pass through unmodified. Misalignment handling belongs to the memory.

Test Plan:
- CPU-only: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF, then a load from the same address -> cpu_stall=0 on both cycles; cpu_rdata=0xDEADBEEF; dbg_gnt=0 throughout.
- Contention aging (MAX_WAIT=4): cpu_req and dbg_req held high -> CPU granted on cycles 0-3, debug granted on cycle 4 with cpu_stall=1 for that cycle; wait_cnt returns to 0; CPU regains the grant on cycle 5.
- Debug read latency: dbg read of 0x20 (containing 0x12345678) with no CPU request -> dbg_gnt same cycle; next cycle dbg_rvalid=1 and dbg_rdata=0x12345678; the following cycle dbg_rvalid=0.
- Lock burst: dbg_lock=1 with 3 writes while cpu_req=1 -> cpu_stall=1 for 3 cycles; drop dbg_lock on the third write -> that write is performed; CPU is granted the next cycle.
- Forced release (LOCK_MAX=16): dbg_lock and dbg_req held high with cpu_req=1 -> FSM returns to ARB after 16 locked cycles; CPU granted for at least 1 cycle; debug re-locks only after the bypass cycle.
- Reset mid-lock: assert rst asynchronously while in LOCK -> mem_we=0, dbg_rvalid=0, state=ARB immediately; after release, a CPU request is granted with no stall.
